// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage RISC-V pipeline: forwarding, load-use stall,
// branch flush, memory-wait freeze and halt. Optional perf counters via HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  if_id_rs1_i,
    input  logic [4:0]  if_id_rs2_i,
    input  logic        id_ex_mem_read_i,
    input  logic [4:0]  id_ex_rd_i,
    input  logic [4:0]  id_ex_rs1_i,
    input  logic [4:0]  id_ex_rs2_i,
    input  logic        ex_mem_reg_write_i,
    input  logic [4:0]  ex_mem_rd_i,
    input  logic        ex_mem_mem_access_i,
    input  logic        mem_wb_reg_write_i,
    input  logic [4:0]  mem_wb_rd_i,
    input  logic        mem_wb_sys_i,
    input  logic        branch_taken_i,
    input  logic        dmem_ready_i,
    input  logic        resume_i,
    output logic        pc_write_o,
    output logic        stall_o,
    output logic        freeze_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        flush_ex_mem_o,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o,
    output logic        halted_o,
    output logic        mem_err_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    state_e     state_q;
    logic [7:0] wdog_q;
    logic       mem_err_q;
    logic       halted_q;
    logic       sys_q;

    logic miss;
    logic sys_rise;
    logic load_use;
    logic flush;

    assign miss     = ex_mem_mem_access_i && !dmem_ready_i;
    // The WB instruction is held while halted, so only a fresh sys assertion is an event.
    assign sys_rise = mem_wb_sys_i && !sys_q;
    assign load_use = id_ex_mem_read_i && (id_ex_rd_i != 5'd0) &&
                      ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));

    // Forwarding: EX/MEM has the younger result and therefore wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_mem_reg_write_i && (ex_mem_rd_i != 5'd0) && (ex_mem_rd_i == rs)) begin
            sel = 2'b10;
        end else if (mem_wb_reg_write_i && (mem_wb_rd_i != 5'd0) && (mem_wb_rd_i == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (rst_ni) begin
            fwd_a_o = fwd_sel(id_ex_rs1_i);
            fwd_b_o = fwd_sel(id_ex_rs2_i);
        end
    end

    always_comb begin
        pc_write_o = rst_ni;
        stall_o    = 1'b0;
        freeze_o   = 1'b0;
        flush      = 1'b0;
        if (rst_ni) begin
            case (state_q)
                StHalt, StMemWait: begin
                    pc_write_o = 1'b0;
                    stall_o    = 1'b1;
                    freeze_o   = 1'b1;
                end
                default: begin
                    if (miss) begin
                        pc_write_o = 1'b0;
                        stall_o    = 1'b1;
                        freeze_o   = 1'b1;
                    end else if (branch_taken_i) begin
                        flush = 1'b1;
                    end else if (load_use) begin
                        pc_write_o = 1'b0;
                        stall_o    = 1'b1;
                    end
                end
            endcase
        end
    end

    assign flush_if_id_o  = flush;
    assign flush_id_ex_o  = flush;
    assign flush_ex_mem_o = flush;
    assign halted_o       = halted_q;
    assign mem_err_o      = mem_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRun;
            wdog_q    <= 8'd0;
            mem_err_q <= 1'b0;
            halted_q  <= 1'b0;
            sys_q     <= 1'b0;
        end else begin
            sys_q <= mem_wb_sys_i;
            case (state_q)
                StRun: begin
                    if (sys_rise) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (miss) begin
                        state_q <= StMemWait;
                        wdog_q  <= 8'd0;
                    end
                end
                StMemWait: begin
                    if (sys_rise) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (dmem_ready_i) begin
                        state_q <= StRun;
                    end else if (wdog_q == TimeoutCnt) begin
                        state_q   <= StHalt;
                        halted_q  <= 1'b1;
                        mem_err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                StHalt: begin
                    if (resume_i && !mem_err_q) begin
                        state_q  <= StRun;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StRun;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush)   flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_events_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4): combinational vector table
// plus hand sequences for memory wait, halt/resume and the watchdog trap.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
    logic        id_ex_mem_read, ex_mem_reg_write, ex_mem_mem_access, mem_wb_reg_write;
    logic        mem_wb_sys, branch_taken, dmem_ready, resume;
    logic        pc_write, stall, freeze, fl_if, fl_id, fl_ex, halted, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles, flush_events;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .if_id_rs1_i         (if_id_rs1),
        .if_id_rs2_i         (if_id_rs2),
        .id_ex_mem_read_i    (id_ex_mem_read),
        .id_ex_rd_i          (id_ex_rd),
        .id_ex_rs1_i         (id_ex_rs1),
        .id_ex_rs2_i         (id_ex_rs2),
        .ex_mem_reg_write_i  (ex_mem_reg_write),
        .ex_mem_rd_i         (ex_mem_rd),
        .ex_mem_mem_access_i (ex_mem_mem_access),
        .mem_wb_reg_write_i  (mem_wb_reg_write),
        .mem_wb_rd_i         (mem_wb_rd),
        .mem_wb_sys_i        (mem_wb_sys),
        .branch_taken_i      (branch_taken),
        .dmem_ready_i        (dmem_ready),
        .resume_i            (resume),
        .pc_write_o          (pc_write),
        .stall_o             (stall),
        .freeze_o            (freeze),
        .flush_if_id_o       (fl_if),
        .flush_id_ex_o       (fl_id),
        .flush_ex_mem_o      (fl_ex),
        .fwd_a_o             (fwd_a),
        .fwd_b_o             (fwd_b),
        .halted_o            (halted),
        .mem_err_o           (mem_err),
        .stall_cycles_o      (stall_cycles),
        .flush_events_o      (flush_events)
    );

    typedef struct {
        string      name;
        logic [4:0] if_rs1, if_rs2;
        logic       mem_read;
        logic [4:0] ex_rd, ex_rs1, ex_rs2;
        logic       exm_we;
        logic [4:0] exm_rd;
        logic       wb_we;
        logic [4:0] wb_rd;
        logic       br;
        logic       e_pc, e_stall;
        logic [2:0] e_flush;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_id_rs1 = 0; if_id_rs2 = 0; id_ex_mem_read = 0; id_ex_rd = 0; id_ex_rs1 = 0;
        id_ex_rs2 = 0; ex_mem_reg_write = 0; ex_mem_rd = 0; ex_mem_mem_access = 0;
        mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_sys = 0; branch_taken = 0;
        dmem_ready = 1; resume = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sc0, fe0;

    initial begin
        //        name        rs1 rs2 mr exrd exs1 exs2 xwe xrd wwe wrd br  pc st fl      fa     fb
        vecs[0]  = '{"idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 2'b00, 2'b00};
        vecs[1]  = '{"lu_rs2",   0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 3'b000, 2'b00, 2'b00};
        vecs[2]  = '{"lu_rd0",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 2'b00, 2'b00};
        vecs[3]  = '{"lu_rs1",   9, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0,  0, 1, 3'b000, 2'b00, 2'b00};
        vecs[4]  = '{"no_load",  9, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 2'b00, 2'b00};
        vecs[5]  = '{"fwd_both", 0, 0, 0, 0, 7, 0, 1, 7, 1, 7, 0,  1, 0, 3'b000, 2'b10, 2'b00};
        vecs[6]  = '{"fwd_wb",   0, 0, 0, 0, 7, 0, 0, 7, 1, 7, 0,  1, 0, 3'b000, 2'b01, 2'b00};
        vecs[7]  = '{"fwd_mix",  0, 0, 0, 0, 4, 3, 1, 3, 1, 4, 0,  1, 0, 3'b000, 2'b01, 2'b10};
        vecs[8]  = '{"fwd_x0",   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0,  1, 0, 3'b000, 2'b00, 2'b00};
        vecs[9]  = '{"br_lu",    0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 1,  1, 0, 3'b111, 2'b00, 2'b00};
        vecs[10] = '{"br_only",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 3'b111, 2'b00, 2'b00};

        // Reset: outputs quiet even with a forwarding match present.
        idle_inputs();
        ex_mem_reg_write = 1; ex_mem_rd = 7; id_ex_rs1 = 7; id_ex_rs2 = 7;
        rst_n = 0;
        #12;
        chk("rst_pc_write", 32'(pc_write), 0);
        chk("rst_fwd", {30'd0, fwd_a | fwd_b}, 0);
        chk("rst_flags", {30'd0, halted, mem_err}, 0);
        chk("rst_freeze_stall", {30'd0, freeze, stall}, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        next_cycle();
        chk("post_rst_pc_write", 32'(pc_write), 1);

        fe0 = flush_events;
        foreach (vecs[i]) begin
            if_id_rs1 = vecs[i].if_rs1; if_id_rs2 = vecs[i].if_rs2;
            id_ex_mem_read = vecs[i].mem_read; id_ex_rd = vecs[i].ex_rd;
            id_ex_rs1 = vecs[i].ex_rs1; id_ex_rs2 = vecs[i].ex_rs2;
            ex_mem_reg_write = vecs[i].exm_we; ex_mem_rd = vecs[i].exm_rd;
            mem_wb_reg_write = vecs[i].wb_we; mem_wb_rd = vecs[i].wb_rd;
            branch_taken = vecs[i].br;
            @(negedge clk);
            chk({vecs[i].name, "_pc"}, 32'(pc_write), 32'(vecs[i].e_pc));
            chk({vecs[i].name, "_stall"}, 32'(stall), 32'(vecs[i].e_stall));
            chk({vecs[i].name, "_flush"}, {29'd0, fl_if, fl_id, fl_ex}, 32'(vecs[i].e_flush));
            chk({vecs[i].name, "_fwd"}, {28'd0, fwd_a, fwd_b},
                {28'd0, vecs[i].e_fa, vecs[i].e_fb});
            chk({vecs[i].name, "_freeze"}, 32'(freeze), 0);
            next_cycle();
        end
        idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
        chk("flush_events_delta", flush_events - fe0, 2);
`else
        chk("flush_events_tied", flush_events, 0);
`endif

        // Memory wait: 3 cycles not ready, then ready -> 4 frozen cycles.
        sc0 = stall_cycles;
        ex_mem_mem_access = 1;
        for (int k = 0; k < 4; k++) begin
            dmem_ready = (k == 3);
            @(negedge clk);
            chk($sformatf("memwait_freeze_%0d", k), {30'd0, freeze, pc_write}, 32'b10);
            chk($sformatf("memwait_stall_%0d", k), 32'(stall), 1);
            next_cycle();
        end
        ex_mem_mem_access = 0; dmem_ready = 1;
        @(negedge clk);
        chk("memwait_back_run", {29'd0, freeze, pc_write, halted}, 32'b010);
`ifdef HAZARD_PERF_CNT_EN
        chk("memwait_stall_cycles", stall_cycles - sc0, 4);
`else
        chk("stall_cycles_tied", stall_cycles, 0);
`endif
        next_cycle();

        // Halt / resume with sys held high across resume.
        mem_wb_sys = 1;
        @(negedge clk);
        chk("sys_pre_edge", {30'd0, halted, pc_write}, 32'b01);
        next_cycle();
        @(negedge clk);
        chk("halt_entered", {29'd0, halted, pc_write, freeze}, 32'b101);
        next_cycle();
        @(negedge clk);
        chk("halt_holds", 32'(halted), 1);
        resume = 1;
        next_cycle();
        resume = 0;
        @(negedge clk);
        chk("resumed", {30'd0, halted, pc_write}, 32'b01);
        next_cycle();
        @(negedge clk);
        chk("sys_level_no_rehalt", 32'(halted), 0);
        mem_wb_sys = 0;
        next_cycle();
        mem_wb_sys = 1;
        next_cycle();
        @(negedge clk);
        chk("sys_new_edge_halt", 32'(halted), 1);
        #2;
        rst_n = 0;
        #1;
        chk("rst_mid_halt", {30'd0, halted, pc_write}, 0);
        mem_wb_sys = 0;
        @(negedge clk);
        rst_n = 1;
        next_cycle();

        // Watchdog: detect edge + 5 MEM_WAIT edges (count 0..4) -> HALT with mem_err.
        ex_mem_mem_access = 1; dmem_ready = 0;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            chk($sformatf("wdog_wait_%0d", k), {30'd0, halted, mem_err}, 0);
        end
        next_cycle();
        chk("wdog_trap", {30'd0, halted, mem_err}, 32'b11);
        ex_mem_mem_access = 0; dmem_ready = 1;
        resume = 1;
        next_cycle();
        resume = 0;
        next_cycle();
        chk("wdog_resume_ignored", {29'd0, halted, mem_err, pc_write}, 32'b110);
        rst_n = 0;
        #1;
        chk("wdog_rst_clears", {30'd0, halted, mem_err}, 0);
        @(negedge clk);
        rst_n = 1;
        next_cycle();
        chk("wdog_after_rst_run", 32'(pc_write), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and produces the following controls:
- **Forwarding selects** for the EX stage.
- **Load-use stall** for the front end.
- **Branch flushes** when a branch resolves in MEM.
- **Whole-pipe freeze** while data memory is busy.
- **Halt/resume** for `ecall`-style system instructions reaching WB.

A small FSM sequences memory-wait and halt. A watchdog bounds memory waits.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before the error trap (8-bit).

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-low reset
- `if_id_rs1`, `if_id_rs2`  in  5 each  source registers of the instruction in ID
- `id_ex_mem_read`  in  1  load in EX
- `id_ex_rd`, `id_ex_rs1`, `id_ex_rs2`  in  5 each  EX-stage register fields
- `ex_mem_reg_write`  in  1  EX/MEM write enable
- `ex_mem_rd`  in  5  EX/MEM destination
- `ex_mem_mem_access`  in  1  load or store in MEM
- `mem_wb_reg_write`  in  1  MEM/WB write enable
- `mem_wb_rd`  in  5  MEM/WB destination
- `mem_wb_sys`  in  1  system instruction in WB
- `branch_taken`  in  1  branch/jump resolved taken in MEM
- `dmem_ready`  in  1  data memory completes the access this cycle
- `resume`  in  1  single-cycle pulse leaving HALT
- `pc_write`  out  1  PC load enable
- `stall`  out  1  IF/ID hold plus ID/EX bubble
- `freeze`  out  1  hold EX/MEM and MEM/WB
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1 each  clear the stage to a bubble
- `fwd_a`, `fwd_b`  out  2 each  operand source: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
- `halted`  out  1  FSM in HALT
- `mem_err`  out  1  sticky watchdog trap
- `stall_cycles`, `flush_events`  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: RUN, MEM_WAIT, HALT.
- **RUN → MEM_WAIT:** `ex_mem_mem_access` && !`dmem_ready`.
- **MEM_WAIT → RUN:** `dmem_ready`.
- **RUN/MEM_WAIT → HALT:** `mem_wb_sys`, or the watchdog count reaching `MEM_TIMEOUT` (this also sets `mem_err`).
- **HALT → RUN:** `resume`. `resume` is ignored while `mem_err` = 1; only reset clears `mem_err`.
- **Forwarding** (combinational, all states):
  - `fwd_a` = 10 if `ex_mem_reg_write` && `ex_mem_rd` != 0 && `ex_mem_rd` == `id_ex_rs1`.
  - Otherwise `fwd_a` = 01 under the same test on the MEM/WB fields.
  - Otherwise `fwd_a` = 00.
  - `fwd_b` follows the same rules with `id_ex_rs2`. EX/MEM wins when both match.
- **Load-use:** `id_ex_mem_read` && `id_ex_rd` != 0 && (`id_ex_rd` == `if_id_rs1` or `id_ex_rd` == `if_id_rs2`). Result: `stall` = 1, `pc_write` = 0 for exactly one cycle.
- **Branch:** `branch_taken` in RUN drives all three flushes = 1 for that cycle. `pc_write` stays 1 so the target loads.
- **MEM_WAIT**, and RUN while the first miss is being detected: `freeze` = `stall` = 1, `pc_write` = 0, flushes = 0.
- **HALT:** `freeze` = `stall` = 1, `pc_write` = 0, `halted` = 1.
- **Priority:** HALT > memory wait > branch flush > load-use. A load-use condition coincident with a branch is dropped.

## Timing
- Forwarding, stall, freeze, flush and `pc_write` are combinational from the inputs and current state, with zero latency.
- FSM state, the watchdog, `mem_err` and the counters update on the rising edge of `clk`.
- Reset (`rst` low, asynchronous) sets:
  - state to RUN, `halted` = 0, `mem_err` = 0, watchdog = 0, counters = 0;
  - `stall`, `freeze`, all flushes and `fwd` outputs to 0, and `pc_write` to 0 while reset is held.
- Release of reset takes effect at the next edge; `pc_write` = 1 in RUN without hazards.
- **Watchdog:**
  - Clears on entering MEM_WAIT and increments each MEM_WAIT cycle without `dmem_ready`.
  - When the count equals `MEM_TIMEOUT`, the next edge goes to HALT.
  - `dmem_ready` in the same cycle wins, and the FSM returns to RUN.
- **`resume` and `mem_wb_sys` in the same HALT cycle:** resume wins. The WB instruction is frozen, so `sys` is not re-sampled as a new event; HALT is re-entered only on a new rising edge of `mem_wb_sys`. This requires a registered copy of `mem_wb_sys`.
- Reset mid-MEM_WAIT or mid-HALT returns to RUN immediately.

## Configuration
- Controlled by the macro `HAZARD_PERF_CNT_EN`.
- **Defined:**
  - `stall_cycles` increments each cycle `stall` = 1.
  - `flush_events` increments each cycle `branch_taken` causes a flush.
  - Both wrap at 2^32 and clear on reset.
- **Undefined:** both outputs are tied to 0 and no counter flops are built.

## Test plan
- **Load-use hazard.** Stimulus: `id_ex_mem_read` = 1, `id_ex_rd` = 5, `if_id_rs2` = 5. Required: `stall` = 1 and `pc_write` = 0 for one cycle, then 0/1. Repeating with `id_ex_rd` = 0 gives no stall.
- **Double forwarding.** Stimulus: `ex_mem_rd` = `mem_wb_rd` = 7, both write enables 1, `id_ex_rs1` = 7. Required: `fwd_a` = 10. Dropping `ex_mem_reg_write` gives `fwd_a` = 01.
- **Branch with load-use.** Stimulus: `branch_taken` = 1 while the load-use condition is true. Required: all three flushes = 1, `stall` = 0, `pc_write` = 1; `flush_events` +1 when the macro is defined.
- **Memory wait.** Stimulus: `ex_mem_mem_access` = 1, `dmem_ready` = 0 for 3 cycles, then 1. Required: `freeze` = 1 for 4 cycles, state returns to RUN, `stall_cycles` = 4.
- **Watchdog trap.** Stimulus: `MEM_TIMEOUT` = 4, `dmem_ready` held 0. Required: HALT after the timeout, with `mem_err` = `halted` = 1. A `resume` pulse is ignored. Reset clears both flags.
- **Halt/resume.** Stimulus: `mem_wb_sys` = 1. Required: `halted` = 1 at the next edge and `pc_write` = 0 until a `resume` pulse, then RUN. Asserting `rst` low mid-HALT immediately gives `halted` = 0.
